// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline without forwarding:
// RAW stalls, taken-branch squashes, HALT sequencing and performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic              id_src1_used,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_dst_wr,
    input  logic              id_halt,
    input  logic              ex_br_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              stall,
    output logic              done,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  stall1_cnt,
    output logic [CNT_W-1:0]  stall2_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef struct packed {
        logic              v;
        logic              wr;
        logic [REG_AW-1:0] dst;
        logic              halt;
    } sb_entry_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    sb_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic      stall_q, stall_d;
    logic      halt_seen_q, halt_seen_d;
    logic      done_q, done_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] stall1_q, stall1_d;
    logic [CNT_W-1:0] stall2_q, stall2_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic id_eff, haz_ex, haz_mem, raw, flush_act, stall_act, advance;

    // WB is never checked: the register file writes before it reads.
    assign haz_ex  = ex_q.v & ex_q.wr &
                     ((id_src1_used & (id_src1 == ex_q.dst)) |
                      (id_src2_used & (id_src2 == ex_q.dst)));
    assign haz_mem = mem_q.v & mem_q.wr &
                     ((id_src1_used & (id_src1 == mem_q.dst)) |
                      (id_src2_used & (id_src2 == mem_q.dst)));

    assign id_eff    = id_valid & ~halt_seen_q & ~done_q;
    assign raw       = id_eff & (haz_ex | haz_mem);
    assign flush_act = ex_br_taken & ex_q.v & ~done_q;
    assign stall_act = raw & ~flush_act;
    assign advance   = id_eff & ~flush_act & ~stall_act;

    always_comb begin
        pc_we       = ~halt_seen_q;
        ifid_we     = ~halt_seen_q;
        ifid_flush  = 1'b0;
        idex_bubble = ~id_eff;
        stall       = 1'b0;
        if (done_q) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (flush_act) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (raw) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            stall       = 1'b1;
        end
    end

    always_comb begin
        ex_d           = ex_q;
        mem_d          = mem_q;
        wb_d           = wb_q;
        stall_d        = stall_act;
        halt_seen_d    = halt_seen_q;
        done_d         = done_q;
        stall_cycles_d = stall_cycles_q;
        stall1_d       = stall1_q;
        stall2_d       = stall2_q;
        flush_d        = flush_q;
        retire_d       = retire_q;
        // Once HALT has retired the whole controller is frozen.
        if (!done_q) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = advance ? '{v: 1'b1, wr: id_dst_wr, dst: id_dst, halt: id_halt} : '0;
            if (advance && id_halt) halt_seen_d = 1'b1;
            if (wb_q.v && wb_q.halt) done_d = 1'b1;
            if (wb_q.v) retire_d = retire_q + ONE;
            if (flush_act) flush_d = flush_q + ONE;
            if (stall_act) begin
                stall_cycles_d = stall_cycles_q + ONE;
                if (!stall_q) begin
                    if (haz_ex) stall2_d = stall2_q + ONE;
                    else        stall1_d = stall1_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_q           <= '0;
            mem_q          <= '0;
            wb_q           <= '0;
            stall_q        <= 1'b0;
            halt_seen_q    <= 1'b0;
            done_q         <= 1'b0;
            stall_cycles_q <= '0;
            stall1_q       <= '0;
            stall2_q       <= '0;
            flush_q        <= '0;
            retire_q       <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
            stall_q        <= stall_d;
            halt_seen_q    <= halt_seen_d;
            done_q         <= done_d;
            stall_cycles_q <= stall_cycles_d;
            stall1_q       <= stall1_d;
            stall2_q       <= stall2_d;
            flush_q        <= flush_d;
            retire_q       <= retire_d;
        end
    end

    assign done         = done_q;
    assign stall_cycles = stall_cycles_q;
    assign stall1_cnt   = stall1_q;
    assign stall2_cnt   = stall2_q;
    assign flush_cnt    = flush_q;
    assign retire_cnt   = retire_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against an in-flight-list reference model.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 32;

    typedef struct {
        logic          v;
        logic [AW-1:0] s1;
        logic          u1;
        logic [AW-1:0] s2;
        logic          u2;
        logic [AW-1:0] d;
        logic          w;
        logic          h;
        logic          br;
    } in_t;

    // exp = {pc_we, ifid_we, ifid_flush, idex_bubble, stall}
    typedef struct {
        in_t        in;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        logic [AW-1:0] dst;
        logic          wr;
        logic          halt;
        int            age;
    } inst_t;

    logic          CLOCK = 1'b0;
    logic          RESET_N;
    logic          id_valid, id_src1_used, id_src2_used, id_dst_wr, id_halt, ex_br_taken;
    logic [AW-1:0] id_src1, id_src2, id_dst;
    logic          pc_we, ifid_we, ifid_flush, idex_bubble, stall, done;
    logic [CW-1:0] stall_cycles, stall1_cnt, stall2_cnt, flush_cnt, retire_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state: instructions that have left ID, with their age
    // (0 = EX, 1 = MEM, 2 = WB).
    inst_t         m_fl[$];
    logic          m_halt_seen, m_done, m_prev_stall;
    logic [CW-1:0] m_sc, m_s1, m_s2, m_fc, m_rc;
    logic [4:0]    e_out;
    logic          e_stall, e_flush, e_adv, e_hex;

    pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dst(id_dst),
        .id_dst_wr(id_dst_wr), .id_halt(id_halt), .ex_br_taken(ex_br_taken),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .stall(stall), .done(done),
        .stall_cycles(stall_cycles), .stall1_cnt(stall1_cnt), .stall2_cnt(stall2_cnt),
        .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic in_t mk(logic v, int s1, logic u1, int s2, logic u2,
                               int d, logic w, logic h, logic br);
        in_t r;
        r.v = v; r.s1 = AW'(s1); r.u1 = u1; r.s2 = AW'(s2); r.u2 = u2;
        r.d = AW'(d); r.w = w; r.h = h; r.br = br;
        return r;
    endfunction

    function automatic in_t idle();
        return mk(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic in_t add(int d, int s1, int s2);
        return mk(1'b1, s1, 1'b1, s2, 1'b1, d, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fl.delete();
        m_halt_seen  = 1'b0;
        m_done       = 1'b0;
        m_prev_stall = 1'b0;
        m_sc = '0; m_s1 = '0; m_s2 = '0; m_fc = '0; m_rc = '0;
    endtask

    // Expected outputs for the current cycle from the in-flight list.
    task automatic model_eval(in_t i);
        logic id_eff, ex_v, hmem, raw;
        id_eff = i.v & !m_halt_seen & !m_done;
        ex_v = 1'b0; e_hex = 1'b0; hmem = 1'b0;
        foreach (m_fl[k]) begin
            if (m_fl[k].age == 0) ex_v = 1'b1;
            if (m_fl[k].age < 2 && m_fl[k].wr &&
                ((i.u1 && i.s1 == m_fl[k].dst) || (i.u2 && i.s2 == m_fl[k].dst))) begin
                if (m_fl[k].age == 0) e_hex = 1'b1;
                else                  hmem  = 1'b1;
            end
        end
        raw     = id_eff & (e_hex | hmem);
        e_flush = i.br & ex_v & !m_done;
        e_stall = raw & !e_flush & !m_done;
        e_adv   = id_eff & !e_flush & !e_stall;
        if (m_done)       e_out = 5'b00010;
        else if (e_flush) e_out = 5'b11110;
        else if (e_stall) e_out = 5'b00011;
        else              e_out = {!m_halt_seen, !m_halt_seen, 1'b0, !id_eff, 1'b0};
    endtask

    task automatic model_commit(in_t i);
        logic retire_halt;
        inst_t n;
        if (m_done) return;
        retire_halt = 1'b0;
        if (e_stall) begin
            m_sc++;
            if (!m_prev_stall) begin
                if (e_hex) m_s2++;
                else       m_s1++;
            end
        end
        m_prev_stall = e_stall;
        if (e_flush) m_fc++;
        foreach (m_fl[k]) begin
            if (m_fl[k].age == 2) begin
                m_rc++;
                if (m_fl[k].halt) retire_halt = 1'b1;
            end
            m_fl[k].age++;
        end
        while (m_fl.size() > 0 && m_fl[0].age > 2) void'(m_fl.pop_front());
        if (e_adv) begin
            n.dst = i.d; n.wr = i.w; n.halt = i.h; n.age = 0;
            m_fl.push_back(n);
            if (i.h) m_halt_seen = 1'b1;
        end
        if (retire_halt) m_done = 1'b1;
    endtask

    task automatic drive(in_t i);
        id_valid = i.v; id_src1 = i.s1; id_src1_used = i.u1;
        id_src2 = i.s2; id_src2_used = i.u2; id_dst = i.d;
        id_dst_wr = i.w; id_halt = i.h; ex_br_taken = i.br;
    endtask

    task automatic compare_model(string tag);
        check_output({tag, ".outs"}, {pc_we, ifid_we, ifid_flush, idex_bubble, stall}, e_out);
        check_output({tag, ".done"}, done, m_done);
        check_output({tag, ".stall_cycles"}, stall_cycles, m_sc);
        check_output({tag, ".stall1"}, stall1_cnt, m_s1);
        check_output({tag, ".stall2"}, stall2_cnt, m_s2);
        check_output({tag, ".flush"}, flush_cnt, m_fc);
        check_output({tag, ".retire"}, retire_cnt, m_rc);
    endtask

    // One clock cycle: inputs after the falling edge, check before the rising edge.
    task automatic apply_stimulus(string tag, in_t i);
        drive(i);
        #2;
        model_eval(i);
        compare_model(tag);
        @(posedge CLOCK);
        model_commit(i);
        @(negedge CLOCK);
    endtask

    task automatic async_reset(string tag);
        #1 RESET_N = 1'b0;
        #1;
        model_reset();
        check_output({tag, ".rst_stall"}, stall, 1'b0);
        check_output({tag, ".rst_pc_we"}, {pc_we, ifid_we, ifid_flush}, 3'b110);
        check_output({tag, ".rst_counters"},
                     {stall_cycles | stall1_cnt | stall2_cnt | flush_cnt | retire_cnt, 31'b0, done}, 64'd0);
        @(posedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    vec_t          tbl[$];
    logic [CW-1:0] frz[5];
    in_t           r;

    initial begin
        drive(idle());
        RESET_N = 1'b0;
        model_reset();
        @(negedge CLOCK);
        #2;
        check_output("reset.outs", {pc_we, ifid_we, ifid_flush, idex_bubble, stall}, 5'b11010);
        check_output("reset.done", done, 1'b0);
        @(negedge CLOCK);
        RESET_N = 1'b1;

        // Four independent instructions back to back.
        for (int k = 0; k < 4; k++) apply_stimulus("indep", add(20 + k, 24 + 2 * k, 25 + 2 * k));
        for (int k = 0; k < 4; k++) apply_stimulus("indep_drain", idle());
        check_output("indep.retire", retire_cnt, 32'd4);
        check_output("indep.stall_cycles", stall_cycles, 32'd0);

        // Directed table: EX-distance stall, MEM-distance stall, branch squash.
        tbl.push_back('{add(3, 1, 2),  5'b11000});
        tbl.push_back('{add(4, 3, 1),  5'b00011});
        tbl.push_back('{add(4, 3, 1),  5'b00011});
        tbl.push_back('{add(4, 3, 1),  5'b11000});
        tbl.push_back('{idle(),        5'b11010});
        tbl.push_back('{add(5, 1, 2),  5'b11000});
        tbl.push_back('{add(6, 7, 8),  5'b11000});
        tbl.push_back('{add(9, 5, 1),  5'b00011});
        tbl.push_back('{add(9, 5, 1),  5'b11000});
        tbl.push_back('{add(10, 5, 1), 5'b11000});
        tbl.push_back('{add(11, 1, 1), 5'b11000});
        tbl.push_back('{mk(1'b1, 2, 1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0), 5'b11000});
        tbl.push_back('{mk(1'b1, 11, 1'b1, 0, 1'b0, 12, 1'b1, 1'b0, 1'b1), 5'b11110});
        tbl.push_back('{mk(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1), 5'b11010});
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].in);
            #2;
            check_output($sformatf("vec%0d", k), {pc_we, ifid_we, ifid_flush, idex_bubble, stall}, tbl[k].exp);
            @(negedge CLOCK);
            if (k == 3) begin
                check_output("raw_ex.stall2", stall2_cnt, 32'd1);
                check_output("raw_ex.stall_cycles", stall_cycles, 32'd2);
            end
            if (k == 8) begin
                check_output("raw_mem.stall1", stall1_cnt, 32'd1);
                check_output("raw_mem.stall2", stall2_cnt, 32'd1);
            end
        end
        check_output("br.flush_cnt", flush_cnt, 32'd1);
        check_output("br.stall_cycles", stall_cycles, 32'd3);

        // HALT with no hazards: done four cycles later, then everything freezes.
        model_reset();
        async_reset("pre_halt");
        apply_stimulus("halt_t0", mk(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0));
        check_output("halt.pc_we_t1", pc_we, 1'b0);
        for (int k = 1; k <= 2; k++) apply_stimulus("halt_wait", add(7, 8, 9));
        check_output("halt.done_t3", done, 1'b0);
        apply_stimulus("halt_t3", add(7, 8, 9));
        check_output("halt.done_t4", done, 1'b1);
        frz = '{stall_cycles, stall1_cnt, stall2_cnt, flush_cnt, retire_cnt};
        for (int k = 0; k < 3; k++) apply_stimulus("frozen", mk(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 1'b1));
        check_output("frozen.counters", {stall_cycles, stall1_cnt, stall2_cnt, flush_cnt, retire_cnt},
                     {frz[0], frz[1], frz[2], frz[3], frz[4]});
        check_output("frozen.retire", retire_cnt, 32'd1);
        check_output("frozen.done", done, 1'b1);

        // HALT squashed by a taken branch in EX.
        async_reset("post_done");
        apply_stimulus("br_halt_prod", add(12, 13, 14));
        apply_stimulus("br_halt", mk(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1));
        for (int k = 0; k < 6; k++) apply_stimulus("br_halt_drain", idle());
        check_output("br_halt.done", done, 1'b0);
        check_output("br_halt.pc_we", pc_we, 1'b1);

        // Reset in the middle of a two-cycle stall.
        apply_stimulus("mid_prod", add(3, 1, 2));
        apply_stimulus("mid_stall", add(4, 3, 1));
        drive(add(4, 3, 1));
        async_reset("mid_stall_rst");
        apply_stimulus("after_rst", add(4, 3, 1));
        check_output("after_rst.stall_cycles", stall_cycles, 32'd0);

        // Randomized traffic with a small register set to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                   $urandom_range(0, 9) == 0);
            apply_stimulus("rand", r);
            if ((m_done && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                drive(idle());
                async_reset("rand_rst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
